// File: rtl/jacobi_pkg.sv
// jacobi_pkg
// Shared definitions for the Jacobi solver front end: the loader FSM state
// encoding, frame geometry and the Q8.8 fixed-point format shared with the
// solver datapath.
//
// Contents:
//   state_t        - loader FSM states S_RECV..S_CLR
//   A_WORDS        - number of matrix words in a frame (3x3, row-major)
//   B_WORDS        - number of right-hand-side words in a frame
//   FRAME_WORDS    - total words in a well-formed frame
//   FRAC_BITS      - fractional bits of the Q8.8 word format
//   is_diag_index  - true for frame positions holding A00, A11, A22
package jacobi_pkg;

    typedef enum logic [2:0] {
        S_RECV  = 3'd0,
        S_DRAIN = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_CLR   = 3'd5
    } state_t;

    localparam int A_WORDS     = 9;
    localparam int B_WORDS     = 3;
    localparam int FRAME_WORDS = A_WORDS + B_WORDS;
    localparam int FRAC_BITS   = 8;

    // Row-major 3x3: the diagonal sits at word indices 0, 4 and 8.
    function automatic logic is_diag_index(input logic [3:0] k);
        return (k == 4'd0) || (k == 4'd4) || (k == 4'd8);
    endfunction

endpackage

// File: rtl/jacobi_timeout_timer.sv
// jacobi_timeout_timer
// Free-running cycle counter used to bound how long the loader waits for the
// solver. The count is cleared while 'clear' is high and advances while
// 'enable' is high; 'expired' flags the last allowed cycle of the window.
//
// Parameters:
//   TIMEOUT_CYCLES - length of the wait window in cycles
//   TMR_W          - counter width, 2**TMR_W must exceed TIMEOUT_CYCLES
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous, active-high reset
//   clear    in   synchronous clear of the count (wins over enable)
//   enable   in   count this cycle
//   expired  out  enable is high and the count has reached TIMEOUT_CYCLES-1
module jacobi_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMR_W          = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The count reads 0 in the first enabled cycle, so matching on
    // TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES enabled cycles.
    assign expired = enable && (count == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/jacobi_frame_loader.sv
// jacobi_frame_loader
// Upstream feeder for the 3x3 Jacobi solver. Receives a framed valid/ready
// stream of 12 Q8.8 words (A row-major, then b), writes them into the
// solver's A/b load ports, starts the solver, waits for done (bounded by a
// timeout), hands x0..x2 out over a valid/ready interface and finally pulses
// solver_clr to re-arm the solver.
//
// Optional feature (compile-time macro DIAG_ZERO_CHECK_EN):
//   When defined, a frame whose A00, A11 or A22 is zero is rejected with a
//   frame_err pulse after its writes instead of being started.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_data/in_valid/in_last   input word stream, in_ready back-pressure
//   a_data/a_addr/a_wen        solver A write port (index 0..8)
//   b_data/b_addr/b_wen        solver b write port (index 0..2)
//   solve_start                one-cycle solver start pulse
//   solver_clr                 one-cycle solver clear pulse
//   solver_done, sx0..sx2      solver status and solution
//   out_x0..out_x2/out_valid   captured solution, out_ready from consumer
//   frame_err, timeout_err     one-cycle error pulses
//   busy                       high whenever not waiting for a new frame
import jacobi_pkg::*;

module jacobi_frame_loader #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMR_W          = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic [3:0]            a_addr,
    output logic                  a_wen,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic [1:0]            b_addr,
    output logic                  b_wen,
    output logic                  solve_start,
    output logic                  solver_clr,
    input  logic                  solver_done,
    input  logic [DATA_WIDTH-1:0] sx0,
    input  logic [DATA_WIDTH-1:0] sx1,
    input  logic [DATA_WIDTH-1:0] sx2,
    output logic [DATA_WIDTH-1:0] out_x0,
    output logic [DATA_WIDTH-1:0] out_x1,
    output logic [DATA_WIDTH-1:0] out_x2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err,
    output logic                  timeout_err,
    output logic                  busy
);

    state_t     state;
    logic [3:0] word_cnt;
    logic       accept;
    logic       tmr_clear;
    logic       tmr_en;
    logic       tmr_expired;

`ifdef DIAG_ZERO_CHECK_EN
    logic       diag_zero;
`endif

    assign in_ready  = (state == S_RECV) || (state == S_DRAIN);
    assign busy      = (state != S_RECV);
    assign accept    = in_valid && in_ready;
    assign tmr_clear = (state == S_START);
    assign tmr_en    = (state == S_WAIT);

    jacobi_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // Single FSM with registered outputs. Pulse outputs default low every
    // cycle and are raised only by the branch that owns them. solve_start
    // is raised while leaving S_START so it lands the cycle after the
    // word-11 write; solver_clr is raised on entry to S_CLR so it is high
    // during that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RECV;
            word_cnt    <= '0;
            a_data      <= '0;
            a_addr      <= '0;
            a_wen       <= 1'b0;
            b_data      <= '0;
            b_addr      <= '0;
            b_wen       <= 1'b0;
            solve_start <= 1'b0;
            solver_clr  <= 1'b0;
            out_x0      <= '0;
            out_x1      <= '0;
            out_x2      <= '0;
            out_valid   <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef DIAG_ZERO_CHECK_EN
            diag_zero   <= 1'b0;
`endif
        end else begin
            a_wen       <= 1'b0;
            b_wen       <= 1'b0;
            solve_start <= 1'b0;
            solver_clr  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                S_RECV: begin
                    if (accept) begin
                        if (word_cnt < 4'(A_WORDS)) begin
                            a_wen  <= 1'b1;
                            a_addr <= word_cnt;
                            a_data <= in_data;
                        end else begin
                            b_wen  <= 1'b1;
                            b_addr <= 2'(word_cnt - 4'(A_WORDS));
                            b_data <= in_data;
                        end

`ifdef DIAG_ZERO_CHECK_EN
                        // Word 0 restarts the sticky flag for the new frame.
                        if (word_cnt == 4'd0) begin
                            diag_zero <= (in_data == '0);
                        end else if (is_diag_index(word_cnt) && (in_data == '0)) begin
                            diag_zero <= 1'b1;
                        end
`endif

                        if (word_cnt == 4'(FRAME_WORDS - 1)) begin
                            word_cnt <= '0;
                            if (in_last) begin
`ifdef DIAG_ZERO_CHECK_EN
                                // The last diagonal word is 8, so the flag
                                // is already final when word 11 arrives.
                                if (diag_zero) begin
                                    frame_err <= 1'b1;
                                end else begin
                                    state <= S_START;
                                end
`else
                                state <= S_START;
`endif
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_DRAIN;
                            end
                        end else if (in_last) begin
                            // Short frame: partial writes stay in the solver
                            // but it is never started on them.
                            frame_err <= 1'b1;
                            word_cnt  <= '0;
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (accept && in_last) begin
                        state <= S_RECV;
                    end
                end

                S_START: begin
                    solve_start <= 1'b1;
                    state       <= S_WAIT;
                end

                S_WAIT: begin
                    // Done wins over a simultaneous timeout.
                    if (solver_done) begin
                        out_x0    <= sx0;
                        out_x1    <= sx1;
                        out_x2    <= sx2;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (tmr_expired) begin
                        timeout_err <= 1'b1;
                        solver_clr  <= 1'b1;
                        state       <= S_CLR;
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        solver_clr <= 1'b1;
                        state      <= S_CLR;
                    end
                end

                S_CLR: begin
                    state <= S_RECV;
                end

                default: begin
                    state <= S_RECV;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jacobi_frame_loader.sv
// tb_jacobi_frame_loader
// Directed self-checking bench for jacobi_frame_loader. A small solver stub
// raises solver_done a fixed number of cycles after solve_start (or never),
// and a negedge monitor logs every write and pulse so the directed steps can
// compare against hand-computed values.
module tb_jacobi_frame_loader;

    localparam int DW         = 16;
    localparam int TMO        = 64;
    localparam int STUB_DELAY = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] a_data;
    logic [3:0]    a_addr;
    logic          a_wen;
    logic [DW-1:0] b_data;
    logic [1:0]    b_addr;
    logic          b_wen;
    logic          solve_start;
    logic          solver_clr;
    logic          solver_done;
    logic [DW-1:0] sx0, sx1, sx2;
    logic [DW-1:0] out_x0, out_x1, out_x2;
    logic          out_valid;
    logic          out_ready;
    logic          frame_err;
    logic          timeout_err;
    logic          busy;

    always #5 clk = ~clk;

    jacobi_frame_loader #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO),
        .TMR_W          (13)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .a_data      (a_data),
        .a_addr      (a_addr),
        .a_wen       (a_wen),
        .b_data      (b_data),
        .b_addr      (b_addr),
        .b_wen       (b_wen),
        .solve_start (solve_start),
        .solver_clr  (solver_clr),
        .solver_done (solver_done),
        .sx0         (sx0),
        .sx1         (sx1),
        .sx2         (sx2),
        .out_x0      (out_x0),
        .out_x1      (out_x1),
        .out_x2      (out_x2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    // Every registered/derived output except in_ready, which is 1 in reset.
    logic [93:0] all_outs;
    assign all_outs = {a_data, a_addr, a_wen, b_data, b_addr, b_wen,
                       solve_start, solver_clr, out_x0, out_x1, out_x2,
                       out_valid, frame_err, timeout_err, busy};

    // Solver stub: done rises STUB_DELAY cycles after solve_start unless
    // stub_never is set, and drops when the loader clears the solver.
    logic stub_never;
    logic stub_run;
    int   stub_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            solver_done <= 1'b0;
            stub_run    <= 1'b0;
            stub_cnt    <= 0;
        end else if (solver_clr) begin
            solver_done <= 1'b0;
            stub_run    <= 1'b0;
        end else if (solve_start) begin
            stub_run <= 1'b1;
            stub_cnt <= 1;
        end else if (stub_run) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt >= STUB_DELAY && !stub_never) solver_done <= 1'b1;
        end
    end

    // Cycle counter and negedge monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          a_total = 0, b_total = 0, start_total = 0, ferr_total = 0;
    int          terr_total = 0, clr_total = 0, ov_total = 0;
    int          last_b_cyc = 0, start_cyc = 0, terr_cyc = 0, clr_cyc = 0, ferr_cyc = 0;
    logic [3:0]  a_log_addr [0:255];
    logic [15:0] a_log_data [0:255];
    logic [1:0]  b_log_addr [0:255];
    logic [15:0] b_log_data [0:255];

    always @(negedge clk) begin
        if (a_wen) begin
            a_log_addr[a_total % 256] <= a_addr;
            a_log_data[a_total % 256] <= a_data;
            a_total <= a_total + 1;
        end
        if (b_wen) begin
            b_log_addr[b_total % 256] <= b_addr;
            b_log_data[b_total % 256] <= b_data;
            b_total    <= b_total + 1;
            last_b_cyc <= cyc;
        end
        if (solve_start) begin
            start_total <= start_total + 1;
            start_cyc   <= cyc;
        end
        if (frame_err) begin
            ferr_total <= ferr_total + 1;
            ferr_cyc   <= cyc;
        end
        if (timeout_err) begin
            terr_total <= terr_total + 1;
            terr_cyc   <= cyc;
        end
        if (solver_clr) begin
            clr_total <= clr_total + 1;
            clr_cyc   <= cyc;
        end
        if (out_valid) ov_total <= ov_total + 1;
    end

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] frame [0:15];

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Sends words 0..n-1 of 'frame', one per accepted cycle; in_last rides
    // on word last_idx (pass a value >= n for no in_last).
    task automatic applyStimulus(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_data  = frame[i];
            in_valid = 1'b1;
            in_last  = (i == last_idx);
            for (int g = 0; g < 100 && !in_ready; g++) @(negedge clk);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic loadGood();
        frame[0]  = 16'h0200; frame[1]  = 16'h0000; frame[2]  = 16'h0000;
        frame[3]  = 16'h0000; frame[4]  = 16'h0200; frame[5]  = 16'h0000;
        frame[6]  = 16'h0000; frame[7]  = 16'h0000; frame[8]  = 16'h0200;
        frame[9]  = 16'h0200; frame[10] = 16'h0400; frame[11] = 16'h0600;
        frame[12] = 16'h1234; frame[13] = 16'h5678;
        frame[14] = 16'h0000; frame[15] = 16'h0000;
    endtask

    task automatic waitOutValid(input string tag);
        for (int i = 0; i < 400 && !out_valid; i++) @(negedge clk);
        checkOutput(tag, 128'(out_valid), 128'd1);
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        checkOutput(tag, 128'(busy), 128'd0);
    endtask

    int a0, b0, s0, f0, t0, c0, ov0, stable_bad;

    initial begin
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        stub_never = 1'b0;
        sx0 = 16'h0100; sx1 = 16'h0200; sx2 = 16'h0300;
        loadGood();

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_outs", 128'(all_outs), 128'd0);
        checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
        rst = 1'b0;
        @(negedge clk);

        // Good frame
        a0 = a_total; b0 = b_total; s0 = start_total;
        applyStimulus(12, 11);
        waitOutValid("good_out_valid");
        checkOutput("good_a_count", 128'(a_total - a0), 128'd9);
        checkOutput("good_b_count", 128'(b_total - b0), 128'd3);
        for (int i = 0; i < 9; i++)
            checkOutput($sformatf("good_a_wr%0d", i),
                        {a_log_addr[(a0 + i) % 256], a_log_data[(a0 + i) % 256]},
                        {4'(i), frame[i]});
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("good_b_wr%0d", i),
                        {b_log_addr[(b0 + i) % 256], b_log_data[(b0 + i) % 256]},
                        {2'(i), frame[9 + i]});
        checkOutput("good_start_count", 128'(start_total - s0), 128'd1);
        checkOutput("good_start_after_write", 128'(start_cyc - last_b_cyc), 128'd1);
        checkOutput("good_out_x", {out_x0, out_x1, out_x2}, {16'h0100, 16'h0200, 16'h0300});

        // Backpressure: hold out_ready low for 20 cycles
        stable_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || {out_x0, out_x1, out_x2} !== {16'h0100, 16'h0200, 16'h0300})
                stable_bad++;
        end
        checkOutput("bp_stable", 128'(stable_bad), 128'd0);
        c0 = clr_total;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release", {out_valid, solver_clr, in_ready}, {1'b0, 1'b1, 1'b0});
        @(negedge clk);
        checkOutput("bp_rearmed", {solver_clr, in_ready, busy}, {1'b0, 1'b1, 1'b0});
        checkOutput("bp_clr_count", 128'(clr_total - c0), 128'd1);

        // Short frame: in_last on word 5
        a0 = a_total; s0 = start_total; f0 = ferr_total;
        applyStimulus(6, 5);
        repeat (3) @(negedge clk);
        checkOutput("short_ferr", 128'(ferr_total - f0), 128'd1);
        checkOutput("short_no_start", 128'(start_total - s0), 128'd0);
        checkOutput("short_a_count", 128'(a_total - a0), 128'd6);
        checkOutput("short_idle", {busy, in_ready}, {1'b0, 1'b1});

        // Following good frame restarts at address 0
        sx0 = 16'h0111; sx1 = 16'h0222; sx2 = 16'h0333;
        a0 = a_total; s0 = start_total;
        applyStimulus(12, 11);
        waitOutValid("after_short_out_valid");
        checkOutput("after_short_first_addr", 128'(a_log_addr[a0 % 256]), 128'd0);
        checkOutput("after_short_start", 128'(start_total - s0), 128'd1);
        checkOutput("after_short_out_x", {out_x0, out_x1, out_x2}, {16'h0111, 16'h0222, 16'h0333});
        waitIdle("after_short_idle");

        // Long frame: 14 words, in_last on word 13
        a0 = a_total; b0 = b_total; s0 = start_total; f0 = ferr_total;
        applyStimulus(14, 13);
        repeat (3) @(negedge clk);
        checkOutput("long_ferr", 128'(ferr_total - f0), 128'd1);
        checkOutput("long_ferr_at_word11", 128'(ferr_cyc - last_b_cyc), 128'd0);
        checkOutput("long_a_count", 128'(a_total - a0), 128'd9);
        checkOutput("long_b_count", 128'(b_total - b0), 128'd3);
        checkOutput("long_no_start", 128'(start_total - s0), 128'd0);
        checkOutput("long_idle", {busy, in_ready}, {1'b0, 1'b1});

        // Timeout: solver never finishes
        stub_never = 1'b1;
        t0 = terr_total; ov0 = ov_total; s0 = start_total;
        applyStimulus(12, 11);
        for (int i = 0; i < 300 && terr_total == t0; i++) @(negedge clk);
        checkOutput("tmo_count", 128'(terr_total - t0), 128'd1);
        checkOutput("tmo_start_count", 128'(start_total - s0), 128'd1);
        checkOutput("tmo_latency", 128'(terr_cyc - start_cyc), 128'(TMO));
        checkOutput("tmo_clr_with_err", 128'(clr_cyc - terr_cyc), 128'd0);
        checkOutput("tmo_no_out_valid", 128'(ov_total - ov0), 128'd0);
        checkOutput("tmo_out_x_held", {out_x0, out_x1, out_x2}, {16'h0111, 16'h0222, 16'h0333});
        @(negedge clk);
        checkOutput("tmo_idle", {busy, in_ready}, {1'b0, 1'b1});
        stub_never = 1'b0;

        // Reset mid-frame after word 6
        applyStimulus(7, 99);
        rst = 1'b1;
        #1;
        checkOutput("midrst_outs", 128'(all_outs), 128'd0);
        checkOutput("midrst_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sx0 = 16'h0AAA; sx1 = 16'h0BBB; sx2 = 16'h0CCC;
        a0 = a_total; b0 = b_total; s0 = start_total;
        applyStimulus(12, 11);
        waitOutValid("midrst_out_valid");
        checkOutput("midrst_first_addr", 128'(a_log_addr[a0 % 256]), 128'd0);
        checkOutput("midrst_a_count", 128'(a_total - a0), 128'd9);
        checkOutput("midrst_start", 128'(start_total - s0), 128'd1);
        checkOutput("midrst_out_x", {out_x0, out_x1, out_x2}, {16'h0AAA, 16'h0BBB, 16'h0CCC});
        waitIdle("midrst_idle");

        // Zero on A11
        frame[4] = 16'h0000;
        a0 = a_total; b0 = b_total; s0 = start_total; f0 = ferr_total;
        applyStimulus(12, 11);
`ifdef DIAG_ZERO_CHECK_EN
        repeat (4) @(negedge clk);
        checkOutput("diag_ferr", 128'(ferr_total - f0), 128'd1);
        checkOutput("diag_no_start", 128'(start_total - s0), 128'd0);
        checkOutput("diag_writes", 128'((a_total - a0) + (b_total - b0)), 128'd12);
        checkOutput("diag_idle", {busy, in_ready}, {1'b0, 1'b1});
`else
        waitOutValid("diag_off_out_valid");
        checkOutput("diag_off_no_ferr", 128'(ferr_total - f0), 128'd0);
        checkOutput("diag_off_start", 128'(start_total - s0), 128'd1);
        checkOutput("diag_off_writes", 128'((a_total - a0) + (b_total - b0)), 128'd12);
        waitIdle("diag_off_idle");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
